// File: rtl/zvc_pkg.sv
// zvc_pkg -- shared definitions for the zero-value compressor line streamer.
//   Default geometry constants (word width, line size, distance field layout,
//   lanes per beat), the derived metadata entry width, and the streamer FSM
//   state encoding.
package zvc_pkg;

   localparam int unsigned ZVC_WORD_WIDTH    = 8;
   localparam int unsigned ZVC_LINE_SIZE     = 128;
   localparam int unsigned ZVC_DIST_WIDTH    = 7;
   localparam int unsigned ZVC_MAX_LIFM_RSIZ = 4;
   localparam int unsigned ZVC_LANES         = 4;

   // Width of one metadata entry: all distance fields of a word.
   localparam int unsigned ZVC_MW = ZVC_DIST_WIDTH * ZVC_MAX_LIFM_RSIZ;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_STREAM = 2'd2
   } zvc_state_e;

endpackage

// File: rtl/zvc_line_streamer_if.sv
// zvc_line_streamer_if -- line-in / beat-out bundle of the line streamer.
//   Line side : in_valid, in_ready, lifm_comp (packed words), mt_comp (packed metadata)
//   Beat side : out_valid, out_ready, out_lifm, out_mt, out_mask, out_last
//   Modports  : slave  = the streamer (accepts lines, produces beats)
//               master = the environment (produces lines, consumes beats)
interface zvc_line_streamer_if
   import zvc_pkg::*;
#(
   parameter int unsigned WORD_WIDTH    = ZVC_WORD_WIDTH,
   parameter int unsigned LINE_SIZE     = ZVC_LINE_SIZE,
   parameter int unsigned DIST_WIDTH    = ZVC_DIST_WIDTH,
   parameter int unsigned MAX_LIFM_RSIZ = ZVC_MAX_LIFM_RSIZ,
   parameter int unsigned LANES         = ZVC_LANES
) ();

   localparam int unsigned MW = DIST_WIDTH * MAX_LIFM_RSIZ;

   logic                          in_valid;
   logic                          in_ready;
   logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp;
   logic [LINE_SIZE*MW-1:0]       mt_comp;

   logic                          out_valid;
   logic                          out_ready;
   logic [LANES*WORD_WIDTH-1:0]   out_lifm;
   logic [LANES*MW-1:0]           out_mt;
   logic [LANES-1:0]              out_mask;
   logic                          out_last;

   modport slave (
      input  in_valid, lifm_comp, mt_comp, out_ready,
      output in_ready, out_valid, out_lifm, out_mt, out_mask, out_last
   );

   modport master (
      output in_valid, lifm_comp, mt_comp, out_ready,
      input  in_ready, out_valid, out_lifm, out_mt, out_mask, out_last
   );

endinterface

// File: rtl/zvc_lead_count.sv
// zvc_lead_count -- leading-valid priority encoder.
//   valid : N validity flags, bit i for entry i
//   count : number of consecutive set flags starting at bit 0 (0..N)
module zvc_lead_count
   import zvc_pkg::*;
#(
   parameter int unsigned N  = ZVC_LINE_SIZE,
   parameter int unsigned CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  valid,
   output logic [CW-1:0] count
);

   logic found;

   // The first cleared flag fixes the count; with no cleared flag the
   // whole vector is a valid run.
   always_comb begin
      count = CW'(N);
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && !valid[i]) begin
            count = CW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/zvc_line_streamer.sv
// zvc_line_streamer -- buffers one compressed line and streams its leading
// valid entries to the PE array, LANES entries per beat.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : zvc_line_streamer_if.slave (line handshake in, beat handshake out)
// Optional feature macro ZVC_STREAM_PERF_CNT_EN adds 32-bit wrapping counters:
//   perf_lines  : accepted lines
//   perf_beats  : accepted beats
//   perf_stalls : cycles with out_valid && !out_ready
module zvc_line_streamer
   import zvc_pkg::*;
#(
   parameter int unsigned WORD_WIDTH    = ZVC_WORD_WIDTH,
   parameter int unsigned LINE_SIZE     = ZVC_LINE_SIZE,
   parameter int unsigned DIST_WIDTH    = ZVC_DIST_WIDTH,
   parameter int unsigned MAX_LIFM_RSIZ = ZVC_MAX_LIFM_RSIZ,
   parameter int unsigned LANES         = ZVC_LANES
) (
   input  logic               clk,
   input  logic               reset,
   zvc_line_streamer_if.slave bus
`ifdef ZVC_STREAM_PERF_CNT_EN
   ,
   output logic [31:0]        perf_lines,
   output logic [31:0]        perf_beats,
   output logic [31:0]        perf_stalls
`endif
);

   localparam int unsigned MW     = DIST_WIDTH * MAX_LIFM_RSIZ;
   localparam int unsigned CW     = $clog2(LINE_SIZE + 1);
   localparam int unsigned IW     = $clog2(LINE_SIZE);
   localparam int unsigned NBEATS = LINE_SIZE / LANES;
   localparam int unsigned PW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned LW     = $clog2(LINE_SIZE * WORD_WIDTH);
   localparam int unsigned TW     = $clog2(LINE_SIZE * MW);

   zvc_state_e state, next_state;

   logic [LINE_SIZE*WORD_WIDTH-1:0] buf_lifm;
   logic [LINE_SIZE*MW-1:0]         buf_mt;
   logic [LINE_SIZE-1:0]            entry_valid;
   logic [CW-1:0]                   lead_count;
   logic [CW-1:0]                   count;
   logic [PW-1:0]                   ptr;
   logic [PW-1:0]                   last_ptr;

   logic in_ready_i;
   logic streaming;
   logic beat_last;
   logic capture;
   logic load_count;
   logic advance;

   // ---------------------------------------------------------------- FSM
   assign in_ready_i = (state == ST_IDLE) && !reset;
   assign streaming  = (state == ST_STREAM);

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      load_count = 1'b0;
      advance    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_i) begin
               capture    = 1'b1;
               next_state = ST_COUNT;
            end
         end
         ST_COUNT: begin
            load_count = 1'b1;
            next_state = ST_STREAM;
         end
         ST_STREAM: begin
            if (bus.out_ready) begin
               if (beat_last) next_state = ST_IDLE;
               else           advance    = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         ptr   <= '0;
         count <= '0;
      end else begin
         state <= next_state;
         if (load_count) begin
            count <= lead_count;
            ptr   <= '0;
         end else if (advance) begin
            ptr <= ptr + 1'b1;
         end
      end
   end

   // ------------------------------------------------------- line buffer
   // Contents only matter after a capture, so the buffer carries no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_lifm <= bus.lifm_comp;
         buf_mt   <= bus.mt_comp;
      end
   end

   for (genvar g = 0; g < LINE_SIZE; g++) begin : g_valid
      assign entry_valid[g] = |buf_mt[g*MW +: MW];
   end

   zvc_lead_count #(
      .N  (LINE_SIZE),
      .CW (CW)
   ) u_lead_count (
      .valid (entry_valid),
      .count (lead_count)
   );

   // An empty line still produces one beat, so the final pointer is
   // ceil(count/LANES)-1 clamped at zero.
   assign last_ptr  = (count == '0) ? '0 : PW'((count - CW'(1)) / CW'(LANES));
   assign beat_last = (ptr == last_ptr);

   // ------------------------------------------------------- beat output
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [CW-1:0] pos;
      logic          lane_on;
      logic [LW-1:0] wsel;
      logic [TW-1:0] msel;

      assign pos     = CW'(ptr) * CW'(LANES) + CW'(j);
      assign lane_on = streaming && (pos < count);
      assign wsel    = LW'(pos[IW-1:0]) * LW'(WORD_WIDTH);
      assign msel    = TW'(pos[IW-1:0]) * TW'(MW);

      assign bus.out_mask[j] = lane_on;
      assign bus.out_lifm[j*WORD_WIDTH +: WORD_WIDTH] =
         lane_on ? buf_lifm[wsel +: WORD_WIDTH] : '0;
      assign bus.out_mt[j*MW +: MW] =
         lane_on ? buf_mt[msel +: MW] : '0;
   end

   assign bus.in_ready  = in_ready_i;
   assign bus.out_valid = streaming;
   assign bus.out_last  = streaming && beat_last;

   // ------------------------------------------------ performance counters
`ifdef ZVC_STREAM_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_lines  <= '0;
         perf_beats  <= '0;
         perf_stalls <= '0;
      end else begin
         if (capture)                       perf_lines  <= perf_lines + 32'd1;
         if (streaming && bus.out_ready)    perf_beats  <= perf_beats + 32'd1;
         if (streaming && !bus.out_ready)   perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule
